// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state type and width helpers for sram_rr_arbiter.
// Imported by the arbiter top and its round-robin picker.
package sram_arb_pkg;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2048;
    localparam int DEF_NREQ  = 4;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Scans i_req upward from i_ptr with wrap-around; lowest offset wins.
module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_sel;

    // Walk from the farthest offset down so the nearest hit is kept.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
            if (w_sum >= (IW + 1)'(NREQ)) begin
                w_sum = w_sum - (IW + 1)'(NREQ);
            end
            w_sel = w_sum[IW-1:0];
            if (i_req[w_sel]) begin
                o_idx = w_sel;
                o_any = 1'b1;
            end
        end
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: round-robin sharing of one single-port SRAM by NREQ requesters.
// Define SRAM_ARB_INIT_CLEAR_EN to build the post-reset zeroing sweep (INIT).
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  DEPTH = DEF_DEPTH,
    parameter int  NREQ  = DEF_NREQ,
    localparam int AW    = idx_w(DEPTH),
    localparam int IW    = idx_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [IW-1:0]         rsp_id,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic [AW-1:0]         sram_addr,
    output logic                  sram_rd_o_wr,
    output logic [WIDTH-1:0]      sram_wdata,
    input  logic [WIDTH-1:0]      sram_rdata,
    output logic                  init_done
);

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_init;
    logic            w_run;
    logic            w_xfer;
    logic            w_rd;
    logic [IW-1:0]   w_ptr_nxt;
    logic [AW-1:0]   w_clr_addr;

    logic [IW-1:0]   r_ptr;
    logic            r_rsp_valid;
    logic [IW-1:0]   r_rsp_id;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    state_e        r_state;
    state_e        w_state_nxt;
    logic [AW-1:0] r_clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_clr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_clr <= r_clr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_clr == AW'(DEPTH - 1)) begin
            w_state_nxt = ST_RUN;
        end
    end

    assign w_init     = rst_n && (r_state == ST_INIT);
    assign w_run      = rst_n && (r_state == ST_RUN);
    assign w_clr_addr = r_clr;
    assign init_done  = rst_n && (r_state == ST_RUN);
`else
    assign w_init     = 1'b0;
    assign w_run      = rst_n;
    assign w_clr_addr = '0;
    assign init_done  = 1'b1;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_xfer    = w_run && w_any;
    assign w_rd      = w_xfer && !req_we[w_idx];
    assign w_ptr_nxt = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    // Outputs are gated by rst_n so the port is quiet during reset.
    always_comb begin
        req_ready    = '0;
        sram_addr    = '0;
        sram_rd_o_wr = 1'b0;
        sram_wdata   = '0;
        if (w_init) begin
            sram_addr    = w_clr_addr;
            sram_rd_o_wr = 1'b1;
        end else if (w_xfer) begin
            req_ready    = w_gnt;
            sram_addr    = req_addr[w_idx*AW +: AW];
            sram_rd_o_wr = req_we[w_idx];
            sram_wdata   = req_wdata[w_idx*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_rd;
            if (w_xfer) begin
                r_ptr <= w_ptr_nxt;
            end
            if (w_rd) begin
                r_rsp_id <= w_idx;
            end
        end
    end

    assign rsp_valid = r_rsp_valid && rst_n;
    assign rsp_id    = r_rsp_id;
    assign rsp_rdata = sram_rdata;

endmodule
